exu_alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the EXU integer ALU. It accepts one operation per handshake and registers the result. Shifts run on an optional iterative shifter, configurable in bits per cycle, to save area on small cores. Conditional branches and JAL are resolved with a mispredict flush and a 2-bit history update. The block sits in the EXU beside the multiplier and divider and drives the same flush/npc interface.

---
 rtl/exu_alu_pkg.sv | 40 ++++
 rtl/exu_alu_mc_if.sv | 38 +++
 rtl/exu_iter_shifter.sv | 71 +++++++
 rtl/exu_alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_exu_alu_mc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_alu_pkg.sv
// Shared types and helpers for the multi-cycle EXU ALU: operation encoding,
// FSM states, op classification and the 2-bit branch history update.
package exu_alu_pkg;

    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
        BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL
    } alu_op_e;

    typedef enum logic {
        IDLE,
        SHIFT
    } alu_state_e;

    function automatic logic is_branch(alu_op_e op);
        return (op == BEQ) || (op == BNE) || (op == BLT) ||
               (op == BGE) || (op == BLTU) || (op == BGEU);
    endfunction

    function automatic logic is_shift(alu_op_e op);
        return (op == SLL) || (op == SRL) || (op == SRA);
    endfunction

    // Counter encoding is h1h0; this is not a plain saturating up/down count.
    function automatic logic [1:0] hist_next(logic [1:0] hist, logic taken);
        logic [1:0] nxt;
        case ({taken, hist})
            3'b100:  nxt = 2'b10;
            3'b101:  nxt = 2'b00;
            3'b110:  nxt = 2'b11;
            3'b111:  nxt = 2'b11;
            3'b000:  nxt = 2'b01;
            3'b001:  nxt = 2'b01;
            3'b010:  nxt = 2'b00;
            default: nxt = 2'b10;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/exu_alu_mc_if.sv
// Operation request / result bundle between the issue stage and the
// multi-cycle ALU.
interface exu_alu_mc_if
    import exu_alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int BRIMM_W = 12
) ();

    logic                in_valid;
    logic                in_ready;
    alu_op_e             op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [XLEN-2:0]     pc;
    logic                rvc;
    logic [BRIMM_W-1:0]  brimm;
    logic                predict_t;
    logic                predict_nt;
    logic [1:0]          hist_in;

    logic                out_valid;
    logic [XLEN-1:0]     out;
    logic                flush_upper;
    logic [XLEN-2:0]     flush_path;
    logic [1:0]          hist_out;

    modport master (
        output in_valid, op, a, b, pc, rvc, brimm, predict_t, predict_nt, hist_in,
        input  in_ready, out_valid, out, flush_upper, flush_path, hist_out
    );

    modport slave (
        input  in_valid, op, a, b, pc, rvc, brimm, predict_t, predict_nt, hist_in,
        output in_ready, out_valid, out, flush_upper, flush_path, hist_out
    );

endinterface

// File: rtl/exu_iter_shifter.sv
// Iterative shifter: moves the operand by up to SHIFT_STEP bits per cycle
// until the remaining distance reaches zero.
module exu_iter_shifter
    import exu_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     kill,
    input  logic                     hold,
    input  alu_op_e                  op,
    input  logic [XLEN-1:0]          a,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    output logic                     done,
    output logic [XLEN-1:0]          res
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP_L = (SHW+1)'(SHIFT_STEP);

    logic [SHW-1:0]          rem_q;
    logic [XLEN-1:0]         sh_q;
    alu_op_e                 op_q;
    logic [SHW:0]            rem_x;
    logic [SHW:0]            step;
    logic signed [XLEN-1:0]  sh_s;
    logic [XLEN-1:0]         sra_step;

    assign rem_x    = {1'b0, rem_q};
    assign step     = (rem_x > STEP_L) ? STEP_L : rem_x;
    assign sh_s     = sh_q;
    // Kept as its own assignment so the shift stays arithmetic.
    assign sra_step = sh_s >>> step;

    always_comb begin
        res = sra_step;
        case (op_q)
            SLL:     res = sh_q << step;
            SRL:     res = sh_q >> step;
            default: res = sra_step;
        endcase
    end

    // rem_q is non-zero only while a shift is in flight.
    assign done = (rem_q != '0) && (rem_x <= STEP_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else if (kill) begin
            rem_q <= '0;
        end else if (start) begin
            rem_q <= shamt;
        end else if (!hold && (rem_q != '0)) begin
            rem_q <= rem_q - step[SHW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sh_q <= a;
            op_q <= op;
        end else if (!hold && (rem_q != '0)) begin
            sh_q <= res;
        end
    end

endmodule

// File: rtl/exu_alu_mc.sv
// Multi-cycle EXU integer ALU: single-cycle arithmetic/logic/branch resolve
// with registered result, plus optional iterative shifting.
module exu_alu_mc
    import exu_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 32,
    parameter int BRIMM_W    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    exu_alu_mc_if.slave bus,
    output logic        busy
);

    localparam int SHW  = $clog2(XLEN);
    localparam bit ITER = (SHIFT_STEP < XLEN);

    alu_state_e              state_q, state_d;
    logic                    accept, go_shift, sh_done, sh_fin;
    logic [SHW-1:0]          shamt;
    logic [XLEN-1:0]         sh_res;

    logic [XLEN-1:0]         sum;
    logic [XLEN:0]           diff;
    logic                    cout, neg, ov, lt_s, lt_u, eq, taken;
    logic signed [XLEN-1:0]  a_s;
    logic [XLEN-1:0]         sra_full, sh_full, sh_imm;
    logic [XLEN-2:0]         pc_inc, br_tgt;

    logic [XLEN-1:0]         res_c;
    logic [XLEN-2:0]         path_c;
    logic [1:0]              hist_c;
    logic                    redir_c;

    logic                    vld_p1, redir_p1;
    logic [XLEN-1:0]         out_p1;
    logic [XLEN-2:0]         path_p1;
    logic [1:0]              hist_p1;

    assign bus.in_ready = (state_q == IDLE) && !freeze;
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign shamt        = bus.b[SHW-1:0];
    assign go_shift     = ITER && is_shift(bus.op) && (shamt != '0);
    assign sh_fin       = (state_q == SHIFT) && sh_done && !freeze && !flush;
    assign busy         = (state_q == SHIFT);

    exu_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && go_shift),
        .kill  (flush),
        .hold  (freeze),
        .op    (bus.op),
        .a     (bus.a),
        .shamt (shamt),
        .done  (sh_done),
        .res   (sh_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (!freeze) begin
            case (state_q)
                IDLE:    if (accept && go_shift) state_d = SHIFT;
                SHIFT:   if (sh_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Subtract as a + ~b + 1 so bit XLEN is the carry-out (1 when a >= b unsigned).
    assign sum  = bus.a + bus.b;
    assign diff = {1'b0, bus.a} + {1'b0, ~bus.b} + {{XLEN{1'b0}}, 1'b1};
    assign cout = diff[XLEN];
    assign neg  = diff[XLEN-1];
    assign ov   = (bus.a[XLEN-1] ^ bus.b[XLEN-1]) & (bus.a[XLEN-1] ^ diff[XLEN-1]);
    assign lt_s = neg ^ ov;
    assign lt_u = ~cout;
    assign eq   = (diff[XLEN-1:0] == '0);

    assign a_s      = bus.a;
    assign sra_full = a_s >>> shamt;
    assign sh_full  = (bus.op == SLL) ? (bus.a << shamt) :
                      (bus.op == SRL) ? (bus.a >> shamt) : sra_full;
    // With the iterative shifter only a zero-distance shift completes here.
    assign sh_imm   = ITER ? bus.a : sh_full;

    assign pc_inc = bus.pc + {{(XLEN-3){1'b0}}, ~bus.rvc, bus.rvc};
    assign br_tgt = bus.pc + {{(XLEN-1-BRIMM_W){bus.brimm[BRIMM_W-1]}}, bus.brimm};

    always_comb begin
        case (bus.op)
            BEQ:     taken = eq;
            BNE:     taken = !eq;
            BLT:     taken = lt_s;
            BGE:     taken = !lt_s;
            BLTU:    taken = lt_u;
            BGEU:    taken = !lt_u;
            JAL:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        res_c = '0;
        case (bus.op)
            ADD:     res_c = sum;
            SUB:     res_c = diff[XLEN-1:0];
            AND:     res_c = bus.a & bus.b;
            OR:      res_c = bus.a | bus.b;
            XOR:     res_c = bus.a ^ bus.b;
            SLL,
            SRL,
            SRA:     res_c = sh_imm;
            SLT:     res_c = {{(XLEN-1){1'b0}}, lt_s};
            SLTU:    res_c = {{(XLEN-1){1'b0}}, lt_u};
            JAL:     res_c = {pc_inc, 1'b0};
            default: res_c = '0;
        endcase
    end

    always_comb begin
        path_c  = '0;
        redir_c = 1'b0;
        hist_c  = bus.hist_in;
        if (is_branch(bus.op)) begin
            path_c  = taken ? br_tgt : pc_inc;
            redir_c = (bus.predict_t & ~taken) | (bus.predict_nt & taken);
            hist_c  = hist_next(bus.hist_in, taken);
        end else if (bus.op == JAL) begin
            path_c  = sum[XLEN-1:1];
            redir_c = 1'b1;
            hist_c  = hist_next(bus.hist_in, 1'b1);
        end
    end

    // ---- result stage (p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            redir_p1 <= 1'b0;
            out_p1   <= '0;
            path_p1  <= '0;
            hist_p1  <= '0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            redir_p1 <= 1'b0;
        end else if (!freeze) begin
            vld_p1 <= 1'b0;
            if (accept && !go_shift) begin
                vld_p1   <= 1'b1;
                out_p1   <= res_c;
                path_p1  <= path_c;
                hist_p1  <= hist_c;
                redir_p1 <= redir_c;
            end else if (accept) begin
                path_p1  <= '0;
                hist_p1  <= bus.hist_in;
                redir_p1 <= 1'b0;
            end else if (sh_fin) begin
                vld_p1 <= 1'b1;
                out_p1 <= sh_res;
            end
        end
    end

    assign bus.out_valid   = vld_p1 && !freeze;
    assign bus.out         = out_p1;
    assign bus.flush_upper = vld_p1 && !freeze && redir_p1;
    assign bus.flush_path  = path_p1;
    assign bus.hist_out    = hist_p1;

endmodule

// File: tb/tb_exu_alu_mc.sv
// Bench for exu_alu_mc (XLEN=32, SHIFT_STEP=4): directed scenarios plus
// random operations checked against a behavioural reference model.
module tb_exu_alu_mc;
    import exu_alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic freeze = 1'b0;
    logic flush = 1'b0;
    logic busy;

    int n_asserts = 0;
    int n_fail = 0;

    localparam logic [1:0] TK_TAB [4] = '{2'b10, 2'b00, 2'b11, 2'b11};
    localparam logic [1:0] NT_TAB [4] = '{2'b01, 2'b01, 2'b00, 2'b10};

    exu_alu_mc_if #(.XLEN(32), .BRIMM_W(12)) bus ();

    exu_alu_mc #(.XLEN(32), .SHIFT_STEP(4), .BRIMM_W(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(
        input int opi, input logic [31:0] a, input logic [31:0] b,
        input logic [30:0] pc, input bit rvc, input logic [11:0] brimm,
        input bit pt, input bit pnt, input logic [1:0] h,
        output logic [31:0] eo, output bit efu, output logic [30:0] ep,
        output logic [1:0] eh, output int lat, output bit ctl);
        int sh;
        bit tk;
        bit is_br;
        logic [30:0] ft;
        logic [30:0] tgt;
        logic [31:0] s;
        sh  = int'(b[4:0]);
        ft  = pc + (rvc ? 31'd1 : 31'd2);
        tgt = pc + 31'($signed(brimm));
        s   = a + b;
        eo = '0; efu = 1'b0; ep = '0; eh = h; lat = 1; ctl = 1'b0;
        tk = 1'b0; is_br = 1'b0;
        case (alu_op_e'(opi))
            ADD:  eo = a + b;
            SUB:  eo = a - b;
            AND:  eo = a & b;
            OR:   eo = a | b;
            XOR:  eo = a ^ b;
            SLL:  eo = a << sh;
            SRL:  eo = a >> sh;
            SRA:  eo = 32'($signed(a) >>> sh);
            SLT:  eo = {31'b0, $signed(a) < $signed(b)};
            SLTU: eo = {31'b0, a < b};
            BEQ:  begin is_br = 1'b1; tk = (a == b); end
            BNE:  begin is_br = 1'b1; tk = (a != b); end
            BLT:  begin is_br = 1'b1; tk = ($signed(a) < $signed(b)); end
            BGE:  begin is_br = 1'b1; tk = ($signed(a) >= $signed(b)); end
            BLTU: begin is_br = 1'b1; tk = (a < b); end
            BGEU: begin is_br = 1'b1; tk = (a >= b); end
            JAL:  begin
                ctl = 1'b1; eo = {ft, 1'b0}; ep = s[31:1]; efu = 1'b1; eh = TK_TAB[h];
            end
            default: eo = '0;
        endcase
        if (is_br) begin
            ctl = 1'b1;
            ep  = tk ? tgt : ft;
            efu = (pt && !tk) || (pnt && tk);
            eh  = tk ? TK_TAB[h] : NT_TAB[h];
        end
        if ((opi == int'(SLL) || opi == int'(SRL) || opi == int'(SRA)) && sh != 0)
            lat = (sh + 3) / 4 + 1;
    endfunction

    task automatic drive(input int opi, input logic [31:0] a, input logic [31:0] b,
                         input logic [30:0] pc, input bit rvc, input logic [11:0] brimm,
                         input bit pt, input bit pnt, input logic [1:0] h);
        bus.op = alu_op_e'(opi);
        bus.a = a; bus.b = b; bus.pc = pc; bus.rvc = rvc; bus.brimm = brimm;
        bus.predict_t = pt; bus.predict_nt = pnt; bus.hist_in = h;
        bus.in_valid = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge where the result shows.
    task automatic run_op(input int opi, input logic [31:0] a, input logic [31:0] b,
                          input logic [30:0] pc, input bit rvc, input logic [11:0] brimm,
                          input bit pt, input bit pnt, input logic [1:0] h);
        logic [31:0] eo; bit efu; logic [30:0] ep; logic [1:0] eh; int lat; bit ctl;
        int cyc;
        model(opi, a, b, pc, rvc, brimm, pt, pnt, h, eo, efu, ep, eh, lat, ctl);
        chk("in_ready", 64'(bus.in_ready), 64'(1));
        drive(opi, a, b, pc, rvc, brimm, pt, pnt, h);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("latency op%0d", opi), 64'(cyc), 64'(lat));
        chk($sformatf("out op%0d", opi), 64'(bus.out), 64'(eo));
        chk($sformatf("flush_upper op%0d", opi), 64'(bus.flush_upper), 64'(efu));
        chk($sformatf("hist_out op%0d", opi), 64'(bus.hist_out), 64'(eh));
        if (ctl) chk($sformatf("flush_path op%0d", opi), 64'(bus.flush_path), 64'(ep));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = ADD; bus.a = '0; bus.b = '0; bus.pc = '0;
        bus.rvc = 1'b0; bus.brimm = '0; bus.predict_t = 1'b0; bus.predict_nt = 1'b0;
        bus.hist_in = '0;

        #2 rst = 1'b1;
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst out", 64'(bus.out), 64'(0));
        chk("rst flush_upper", 64'(bus.flush_upper), 64'(0));
        chk("rst flush_path", 64'(bus.flush_path), 64'(0));
        chk("rst hist_out", 64'(bus.hist_out), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst in_ready", 64'(bus.in_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Signed overflow on ADD and SLT.
        run_op(int'(ADD), 32'h7FFF_FFFF, 32'd1, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
        run_op(int'(SLT), 32'h7FFF_FFFF, 32'd1, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);

        // Iterative SRA: three busy cycles, then the result.
        drive(int'(SRA), 32'h8000_0000, 32'd10, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("sra busy c%0d", i), 64'(busy), 64'(1));
            chk($sformatf("sra in_ready c%0d", i), 64'(bus.in_ready), 64'(0));
            chk($sformatf("sra out_valid c%0d", i), 64'(bus.out_valid), 64'(0));
        end
        @(negedge clk);
        chk("sra out_valid c4", 64'(bus.out_valid), 64'(1));
        chk("sra out", 64'(bus.out), 64'h0000_0000_FFE0_0000);
        chk("sra busy c4", 64'(busy), 64'(0));

        // Branch and jump corner cases.
        run_op(int'(BEQ), 32'd5, 32'd5, 31'h80, 1'b0, 12'h010, 1'b0, 1'b1, 2'b01);
        run_op(int'(BNE), 32'd7, 32'd7, 31'h80, 1'b0, 12'h010, 1'b0, 1'b1, 2'b00);
        run_op(int'(JAL), 32'h400, 32'd8, 31'h100, 1'b1, '0, 1'b0, 1'b0, 2'b00);
        run_op(int'(BLT), 32'hFFFF_FFFF, 32'd1, 31'h7FFF_FFFF, 1'b0, 12'hFFE, 1'b1, 1'b0, 2'b11);

        for (int n = 0; n < 40; n++) begin
            int opi; int pr;
            logic [31:0] ra, rb;
            opi = $urandom_range(0, 16);
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 31));
            pr = $urandom_range(0, 2);
            run_op(opi, ra, rb, 31'($urandom), 1'($urandom), 12'($urandom),
                   pr == 1, pr == 2, 2'($urandom));
        end

        // Freeze holds the pending result and re-presents it afterwards.
        drive(int'(ADD), 32'd100, 32'd23, '0, 1'b0, '0, 1'b0, 1'b0, 2'b10);
        @(negedge clk);
        bus.in_valid = 1'b0;
        freeze = 1'b1;
        #1 chk("frz out_valid f1", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        chk("frz out_valid f2", 64'(bus.out_valid), 64'(0));
        chk("frz in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        chk("frz out_valid f3", 64'(bus.out_valid), 64'(0));
        freeze = 1'b0;
        #1 chk("frz out_valid release", 64'(bus.out_valid), 64'(1));
        chk("frz out", 64'(bus.out), 64'd123);
        chk("frz hist_out", 64'(bus.hist_out), 64'(2'b10));
        @(negedge clk);
        chk("frz pulse end", 64'(bus.out_valid), 64'(0));

        // Flush in the offer cycle blocks the accept.
        drive(int'(ADD), 32'd1, 32'd2, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush-accept out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush-accept busy", 64'(busy), 64'(0));

        // Flush in the middle of a long SRL.
        drive(int'(SRL), 32'hDEAD_BEEF, 32'd31, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("srl busy c%0d", i), 64'(busy), 64'(1));
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        chk("flush out_valid", 64'(bus.out_valid), 64'(0));
        chk("flush in_ready", 64'(bus.in_ready), 64'(1));
        run_op(int'(ADD), 32'd40, 32'd2, '0, 1'b0, '0, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("flushed srl silent %0d", i), 64'(bus.out_valid), 64'(0));
        end

        // Asynchronous reset in the middle of a shift.
        run_op(int'(JAL), 32'h1234, 32'h10, 31'h555, 1'b0, '0, 1'b0, 1'b0, 2'b01);
        drive(int'(SLL), 32'h0000_0001, 32'd20, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(bus.out_valid), 64'(0));
        chk("arst out", 64'(bus.out), 64'(0));
        chk("arst flush_upper", 64'(bus.flush_upper), 64'(0));
        chk("arst flush_path", 64'(bus.flush_path), 64'(0));
        chk("arst hist_out", 64'(bus.hist_out), 64'(0));
        chk("arst busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op(int'(SLL), 32'h0000_0001, 32'd20, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
